// File: rtl/uart_tx_buf.sv
// uart_tx_buf: byte-wide transmit FIFO feeding an 8N1 UART serialiser.
//
// Parameters
//   CLKS_PER_BIT : clk cycles per serial bit period (2..65535)
//   FIFO_DEPTH   : byte entries in the transmit FIFO (power of two, 2..16)
//
// Ports
//   clk      : sole clock, rising-edge
//   rst      : asynchronous active-high reset
//   din      : byte to enqueue, sampled when wr_en=1
//   wr_en    : enqueue request, one byte per cycle
//   tx       : registered serial line, idle high
//   full     : FIFO holds FIFO_DEPTH bytes
//   empty    : FIFO holds no bytes
//   busy     : a frame is in progress
//   overflow : sticky flag, a write was dropped because the FIFO was full
//   count    : current FIFO occupancy
module uart_tx_buf #(
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [7:0]                    din,
   input  logic                          wr_en,
   output logic                          tx,
   output logic                          full,
   output logic                          empty,
   output logic                          busy,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   count
);

   localparam int AW   = $clog2(FIFO_DEPTH);
   localparam int CNTW = AW + 1;
   localparam logic [15:0]     BIT_LAST = 16'(CLKS_PER_BIT - 1);
   localparam logic [CNTW-1:0] DEPTH_C  = CNTW'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t            state_q, state_d;
   logic [15:0]       bit_cnt_q, bit_cnt_d;
   logic [2:0]        idx_q, idx_d;
   logic [7:0]        shift_q, shift_d;
   logic              tx_q, tx_d;
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CNTW-1:0]   count_q, count_d;
   logic              full_q, full_d;
   logic              empty_q, empty_d;
   logic              ovf_q, ovf_d;
   logic [7:0]        mem_q [FIFO_DEPTH];

   logic push;
   logic pop;
   logic bit_end;
   logic have_data;

   // Writes are decided on the registered full flag so a pop in the same
   // cycle never makes room for a byte that arrived while full.
   assign push      = wr_en & ~full_q;
   assign have_data = (count_q != '0);
   assign bit_end   = (bit_cnt_q == BIT_LAST);

   // Serialiser FSM
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      idx_d     = idx_q;
      shift_d   = shift_q;
      tx_d      = tx_q;
      pop       = 1'b0;
      case (state_q)
         IDLE: begin
            tx_d = 1'b1;
            if (have_data) begin
               pop       = 1'b1;
               shift_d   = mem_q[rd_ptr_q];
               tx_d      = 1'b0;
               bit_cnt_d = '0;
               state_d   = START;
            end
         end
         START: begin
            if (bit_end) begin
               bit_cnt_d = '0;
               tx_d      = shift_q[0];
               idx_d     = 3'd0;
               state_d   = DATA;
            end else begin
               bit_cnt_d = bit_cnt_q + 16'd1;
            end
         end
         DATA: begin
            if (bit_end) begin
               bit_cnt_d = '0;
               if (idx_q == 3'd7) begin
                  tx_d    = 1'b1;
                  state_d = STOP;
               end else begin
                  // shift_q[0] is the bit on the line; the next one is [1]
                  idx_d   = idx_q + 3'd1;
                  shift_d = {1'b0, shift_q[7:1]};
                  tx_d    = shift_q[1];
               end
            end else begin
               bit_cnt_d = bit_cnt_q + 16'd1;
            end
         end
         STOP: begin
            if (bit_end) begin
               bit_cnt_d = '0;
               if (have_data) begin
                  // back-to-back frame: start bit follows stop bit directly
                  pop     = 1'b1;
                  shift_d = mem_q[rd_ptr_q];
                  tx_d    = 1'b0;
                  state_d = START;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               bit_cnt_d = bit_cnt_q + 16'd1;
            end
         end
         default: begin
            state_d = IDLE;
            tx_d    = 1'b1;
         end
      endcase
   end

   // FIFO bookkeeping; pointers wrap naturally since depth is a power of two
   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d  = count_q + CNTW'(push) - CNTW'(pop);
      full_d   = (count_d == DEPTH_C);
      empty_d  = (count_d == '0);
      ovf_d    = ovf_q | (wr_en & full_q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         bit_cnt_q <= '0;
         idx_q     <= '0;
         shift_q   <= '0;
         tx_q      <= 1'b1;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         full_q    <= 1'b0;
         empty_q   <= 1'b1;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         idx_q     <= idx_d;
         shift_q   <= shift_d;
         tx_q      <= tx_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         full_q    <= full_d;
         empty_q   <= empty_d;
         ovf_q     <= ovf_d;
      end
   end

   // Byte storage carries no reset; occupancy alone says what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

   assign tx       = tx_q;
   assign full     = full_q;
   assign empty    = empty_q;
   assign busy     = (state_q != IDLE);
   assign overflow = ovf_q;
   assign count    = count_q;

endmodule

// File: tb/tb_uart_tx_buf.sv
// Bench for uart_tx_buf with CLKS_PER_BIT=4, FIFO_DEPTH=4. The reference is a
// byte queue plus a frame timeline: each frame lasts 10 bit periods and the
// expected line level is looked up from the elapsed time within the frame.
module tb_uart_tx_buf;

   localparam int N = 4;
   localparam int D = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       wr_en;
   logic [7:0] din;
   logic       tx, full, empty, busy, overflow;
   logic [2:0] count;

   int total = 0;
   int bad   = 0;

   // reference model state
   byte unsigned mq[$];
   int           rem;
   logic [7:0]   cur;
   logic         ovf_m;

   uart_tx_buf #(.CLKS_PER_BIT(N), .FIFO_DEPTH(D)) dut (
      .clk      (clk),
      .rst      (rst),
      .din      (din),
      .wr_en    (wr_en),
      .tx       (tx),
      .full     (full),
      .empty    (empty),
      .busy     (busy),
      .overflow (overflow),
      .count    (count)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      rem   = 0;
      cur   = 8'h00;
      ovf_m = 1'b0;
   endtask

   function automatic logic exp_tx();
      int k;
      if (rem == 0) return 1'b1;
      k = (10 * N - rem) / N;
      if (k == 0) return 1'b0;
      if (k == 9) return 1'b1;
      return cur[k-1];
   endfunction

   // One rising edge of the reference: frame time advances, a waiting byte
   // starts a frame when the line is free, then the write is judged against
   // the occupancy seen before the edge.
   task automatic model_edge(input logic w, input logic [7:0] d);
      int pre;
      pre = mq.size();
      if (rst) begin
         model_reset();
         return;
      end
      if (rem > 0) rem--;
      if (rem == 0 && pre > 0) begin
         cur = mq.pop_front();
         rem = 10 * N;
      end
      if (w) begin
         if (pre < D) mq.push_back(d);
         else ovf_m = 1'b1;
      end
   endtask

   task automatic check_all();
      chk("tx",       32'(tx),       32'(exp_tx()));
      chk("busy",     32'(busy),     32'(rem > 0));
      chk("count",    32'(count),    32'(mq.size()));
      chk("full",     32'(full),     32'(mq.size() == D));
      chk("empty",    32'(empty),    32'(mq.size() == 0));
      chk("overflow", 32'(overflow), 32'(ovf_m));
   endtask

   task automatic step(input logic w, input logic [7:0] d);
      wr_en = w;
      din   = d;
      @(posedge clk);
      model_edge(w, d);
      #1;
      check_all();
   endtask

   initial begin
      rst   = 1'b1;
      wr_en = 1'b0;
      din   = 8'h00;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all();
      rst = 1'b0;
      repeat (3) step(1'b0, 8'h00);

      // single byte 0xA5 from idle
      step(1'b1, 8'hA5);
      repeat (2) step(1'b0, 8'h00);
      chk("a5_start_low", 32'(tx), 32'd0);
      chk("a5_busy", 32'(busy), 32'd1);
      chk("a5_empty_after_pop", 32'(empty), 32'd1);
      repeat (45) step(1'b0, 8'h00);
      chk("a5_idle_after", 32'(busy), 32'd0);

      // five back-to-back writes, then one while full
      for (int i = 1; i <= 5; i++) step(1'b1, 8'(i));
      chk("five_full", 32'(full), 32'd1);
      chk("five_no_ovf", 32'(overflow), 32'd0);
      step(1'b1, 8'hFF);
      chk("ff_ovf", 32'(overflow), 32'd1);
      chk("ff_count", 32'(count), 32'd4);
      for (int i = 0; i < 400 && (rem > 0 || mq.size() > 0); i++) step(1'b0, 8'h00);
      repeat (3) step(1'b0, 8'h00);
      chk("five_drained", 32'(busy), 32'd0);
      chk("ovf_sticky", 32'(overflow), 32'd1);

      // reset during data bit 3 of 0x3C with two bytes waiting
      step(1'b1, 8'h3C);
      step(1'b1, 8'h11);
      step(1'b1, 8'h22);
      for (int i = 0; i < 60 && (10 * N - rem) != 17; i++) step(1'b0, 8'h00);
      chk("bit3_level", 32'(tx), 32'd1);
      chk("bit3_queued", 32'(count), 32'd2);
      rst = 1'b1;
      #1;
      chk("rst_tx", 32'(tx), 32'd1);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_ovf", 32'(overflow), 32'd0);
      model_reset();
      @(posedge clk);
      #1;
      check_all();
      rst = 1'b0;
      repeat (5) step(1'b0, 8'h00);
      step(1'b1, 8'h55);
      repeat (45) step(1'b0, 8'h00);

      // write every cycle with random data
      for (int i = 0; i < 200; i++) step(1'b1, 8'($urandom));
      for (int i = 0; i < 2000 && (rem > 0 || mq.size() > 0); i++) step(1'b0, 8'h00);
      repeat (3) step(1'b0, 8'h00);
      chk("rand_idle", 32'(busy), 32'd0);
      chk("rand_empty", 32'(empty), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
